mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised data-memory access unit between the CPU execute/memory stage and synchronous data RAM.
- Loads: extracts byte/half/word/(dword) at any aligned offset, zero- or sign-extends, registers the result.
- Stores: generates per-byte write enables and lane-replicated write data.
- Valid/ready request handshake; waits on a memory acknowledge to tolerate multi-cycle RAM.

Parameters:
DATA_W, 32, data bus width; legal values 32 or 64.
ADDR_W, 32, byte address width.
NB, DATA_W/8, byte lanes (derived; not overridden).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
req_valid  input  1  access request.
req_ready  output  1  unit can accept a request (IDLE).
req_we  input  1  1=store, 0=load.
req_size  input  2  00=word, 01=half, 10=byte, 11=dword (DATA_W=64 only).
req_sext  input  1  sign-extend load result.
req_addr  input  ADDR_W  byte address.
req_wdata  input  DATA_W  store data, right-justified.
resp_valid  output  1  one-cycle pulse: access complete.
resp_rdata  output  DATA_W  extended load data; 0 for stores.
resp_misalign  output  1  access was misaligned (valid with resp_valid).
mem_en  output  1  memory access strobe.
mem_we  output  NB  byte write enables.
mem_addr  output  ADDR_W  bus-aligned address (low log2(NB) bits zero).
mem_wdata  output  DATA_W  lane-replicated store data.
mem_rdata  input  DATA_W  read data, valid when mem_ack=1.
mem_ack  input  1  memory completion.

Behaviour:
- Clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_misalign=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-access abandons the access; no response is issued.
- FSM states IDLE, ACCESS, RESP.
  - IDLE: req_ready=1. On req_valid, latch the request and go to ACCESS. mem_en/mem_we/mem_addr/mem_wdata are registered and asserted from the next cycle.
  - ACCESS: mem_en=1 and outputs held stable until mem_ack=1. On the ack cycle, capture mem_rdata and go to RESP. An ack arriving in the first ACCESS cycle gives minimum latency.
  - RESP: resp_valid=1 for exactly one cycle; mem_en=0, mem_we=0. Next state is IDLE. req_ready=0 in RESP, so no back-to-back overlap.
- Minimum latency: request to resp_valid is 3 cycles.
- Lane offset off = addr[log2(NB)-1:0], used with size-aligned bits.
- Byte store: mem_we has a single bit set at lane off; wdata[7:0] is replicated to every lane.
- Half store: 2 bits set at off&~1; wdata[15:0] is replicated.
- Word store: 4 bits set at off&~3.
- Dword store: all bits set.
- Load: shift mem_rdata right by 8*lane, keep the size's bits, then fill upper bits with the sign bit when req_sext=1, else zero. Word load with DATA_W=32 ignores req_sext.
- req_size=11 with DATA_W=32: treated as word.
- mem_addr always has its low log2(NB) bits cleared.

Optional Feature:
- MISALIGN_CHECK_EN defined:
  - A half with addr[0]!=0, word with addr[1:0]!=0, or dword with addr[2:0]!=0 skips ACCESS: IDLE, then RESP, with resp_misalign=1 and resp_rdata=0.
  - mem_en never asserts for such requests; stores never write.
- Not defined:
  - Offending low address bits are masked to size alignment.
  - The access proceeds normally; resp_misalign is tied 0.

Decomposition:
- Shared package mem_pkg holds:
  - size codes SZ_WORD/SZ_HALF/SZ_BYTE/SZ_DWORD;
  - the FSM state encoding;
  - the lane-count function.
- Sub-module load_extend: combinational shift/mask/sign-extend of captured read data by size/offset/sext. This is the generalised successor of the existing load extender and is reusable by the cache refill path.

Test Plan:
- DATA_W=32, store byte 0xA5 at addr 0x103, ack delay 0 -> mem_we=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100, resp_valid in cycle 3.
- Load half sext at 0x102 with mem_rdata=0x80001234 -> resp_rdata=0xFFFF8000; the same load with sext=0 -> 0x00008000.
- Load byte sext at 0x101 with mem_rdata=0x00007F00, ack after 4 wait cycles -> resp_rdata=0x0000007F; mem_en and mem_addr are stable through all waits; resp_valid is exactly 1 cycle.
- DATA_W=64, dword load at 0x8 -> full mem_rdata returned, mem_we=0; word store at 0xC -> mem_we=8'hF0.
- MISALIGN_CHECK_EN, word store at 0x102 -> mem_en never asserts, resp_misalign=1, resp_rdata=0. Without the macro -> mem_we=4'hF at 0x100.
- rst asserted during ACCESS -> next cycle IDLE with all outputs 0 and req_ready=1; no resp_valid; a new request is accepted afterwards.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: size codes, FSM encoding, lane count.
package mem_pkg;

  localparam logic [1:0] SZ_WORD  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_BYTE  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extractor: shifts the addressed lane down, masks to the access size, zero/sign-extends.
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]              rdata,
  input  logic [1:0]                     size,
  input  logic [$clog2(DATA_W/8)-1:0]    off,
  input  logic                           sext,
  output logic [DATA_W-1:0]              ext
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sign;

  assign shifted = rdata >> {off, 3'b000};

  // A full-width access has an all-ones mask, so sext has no effect on it.
  always_comb begin
    mask = '1;
    sign = 1'b0;
    case (size)
      SZ_BYTE: begin
        mask = DATA_W'(8'hFF);
        sign = shifted[7];
      end
      SZ_HALF: begin
        mask = DATA_W'(16'hFFFF);
        sign = shifted[15];
      end
      SZ_WORD: begin
        mask = DATA_W'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: begin
        mask = '1;
        sign = 1'b0;
      end
    endcase
    ext = (shifted & mask) | ((sext && sign) ? ~mask : '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: request handshake, byte-enable/replicated store data, extended loads.
// Optional misaligned-access trapping is enabled by defining MISALIGN_CHECK_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [1:0]                   req_size,
  input  logic                         req_sext,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         resp_valid,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         resp_misalign,
  output logic                         mem_en,
  output logic [lane_count(DATA_W)-1:0] mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_ack
);

  localparam int NB = lane_count(DATA_W);
  localparam int OB = $clog2(NB);

  state_e            state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic [NB-1:0]     mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [OB-1:0]     off_q, off_d;

  logic [1:0]        size_eff;
  logic [OB-1:0]     off_raw;
  logic [OB-1:0]     align_mask;
  logic [OB-1:0]     off_al;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wrep;
  logic [DATA_W-1:0] ext;
  logic              misaligned;

  // A dword request on a 32-bit bus degenerates to a word access.
  assign size_eff = (DATA_W == 32 && req_size == SZ_DWORD) ? SZ_WORD : req_size;
  assign off_raw  = req_addr[OB-1:0];

  always_comb begin
    align_mask = '0;
    be         = '1;
    wrep       = req_wdata;
    case (size_eff)
      SZ_BYTE: begin
        align_mask = '1;
        wrep       = {NB{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        align_mask = ~OB'(1);
        wrep       = {(NB/2){req_wdata[15:0]}};
      end
      SZ_WORD: begin
        align_mask = ~OB'(3);
        wrep       = {(NB/4){req_wdata[31:0]}};
      end
      default: begin
        align_mask = '0;
        wrep       = req_wdata;
      end
    endcase
    off_al = off_raw & align_mask;
    case (size_eff)
      SZ_BYTE: be = NB'(1) << off_al;
      SZ_HALF: be = NB'(3) << off_al;
      SZ_WORD: be = NB'(15) << off_al;
      default: be = '1;
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misaligned    = |(off_raw & ~align_mask);
  assign resp_misalign = misalign_q;
`else
  assign misaligned    = 1'b0;
  assign resp_misalign = 1'b0;
`endif

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .rdata (mem_rdata),
    .size  (size_q),
    .off   (off_q),
    .sext  (sext_q),
    .ext   (ext)
  );

  always_comb begin
    state_d      = state_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    we_d         = we_q;
    size_d       = size_q;
    sext_d       = sext_q;
    off_d        = off_q;
`ifdef MISALIGN_CHECK_EN
    misalign_d   = misalign_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d         = req_we;
          size_d       = size_eff;
          sext_d       = req_sext;
          off_d        = off_al;
          resp_rdata_d = '0;
          if (misaligned) begin
            state_d = ST_RESP;
`ifdef MISALIGN_CHECK_EN
            misalign_d = 1'b1;
`endif
          end else begin
            state_d     = ST_ACCESS;
            mem_en_d    = 1'b1;
            mem_we_d    = req_we ? be : '0;
            mem_addr_d  = {req_addr[ADDR_W-1:OB], OB'(0)};
            mem_wdata_d = req_we ? wrep : '0;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d      = ST_RESP;
          mem_en_d     = 1'b0;
          mem_we_d     = '0;
          resp_rdata_d = we_q ? '0 : ext;
        end
      end
      ST_RESP: begin
        state_d      = ST_IDLE;
        resp_rdata_d = '0;
`ifdef MISALIGN_CHECK_EN
        misalign_d   = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_en_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
`ifdef MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef MISALIGN_CHECK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  // Request attributes only matter while a transaction is in flight.
  always_ff @(posedge clk) begin
    we_q   <= we_d;
    size_q <= size_d;
    sext_q <= sext_d;
    off_q  <= off_d;
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: 32-bit and 64-bit instances, hand-computed expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  int          vectors = 0;
  int          miscompares = 0;

  logic        a_req_valid, a_req_we, a_req_sext, a_mem_ack;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata, a_mem_rdata;
  logic        a_req_ready, a_resp_valid, a_resp_misalign, a_mem_en;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_we;

  logic        b_req_valid, b_req_we, b_req_sext, b_mem_ack;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata, b_mem_rdata;
  logic        b_req_ready, b_resp_valid, b_resp_misalign, b_mem_en;
  logic [63:0] b_resp_rdata, b_mem_wdata;
  logic [31:0] b_mem_addr;
  logic [7:0]  b_mem_we;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_size(a_req_size), .req_sext(a_req_sext),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .resp_valid(a_resp_valid),
    .resp_rdata(a_resp_rdata), .resp_misalign(a_resp_misalign), .mem_en(a_mem_en),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_size(b_req_size), .req_sext(b_req_sext),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid),
    .resp_rdata(b_resp_rdata), .resp_misalign(b_resp_misalign), .mem_en(b_mem_en),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the 32-bit unit with a given number of ack wait cycles.
  task automatic do32(input string tag, input logic we, input logic [1:0] size, input logic sext,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                      input int delay, input logic [3:0] exp_we, input logic [31:0] exp_wdata,
                      input logic [31:0] exp_addr, input logic [31:0] exp_rdata);
    @(negedge clk);
    chk({tag, ".ready"}, 64'(a_req_ready), 64'd1);
    a_req_valid = 1'b1; a_req_we = we; a_req_size = size; a_req_sext = sext;
    a_req_addr = addr; a_req_wdata = wdata;
    tick();
    a_req_valid = 1'b0;
    chk({tag, ".resp_early"}, 64'(a_resp_valid), 64'd0);
    for (int n = 0; n <= delay; n++) begin
      chk({tag, ".en"}, 64'(a_mem_en), 64'd1);
      chk({tag, ".addr"}, 64'(a_mem_addr), 64'(exp_addr));
      chk({tag, ".we"}, 64'(a_mem_we), 64'(exp_we));
      if (we) chk({tag, ".wdata"}, 64'(a_mem_wdata), 64'(exp_wdata));
      chk({tag, ".busy"}, 64'(a_req_ready), 64'd0);
      if (n == delay) begin
        a_mem_ack = 1'b1;
        a_mem_rdata = rdata;
      end
      tick();
      a_mem_ack = 1'b0;
      a_mem_rdata = 32'h0;
      if (n < delay) chk({tag, ".resp_wait"}, 64'(a_resp_valid), 64'd0);
    end
    chk({tag, ".resp_valid"}, 64'(a_resp_valid), 64'd1);
    chk({tag, ".rdata"}, 64'(a_resp_rdata), 64'(exp_rdata));
    chk({tag, ".misalign"}, 64'(a_resp_misalign), 64'd0);
    chk({tag, ".en_off"}, 64'(a_mem_en), 64'd0);
    chk({tag, ".we_off"}, 64'(a_mem_we), 64'd0);
    tick();
    chk({tag, ".resp_done"}, 64'(a_resp_valid), 64'd0);
    chk({tag, ".ready_back"}, 64'(a_req_ready), 64'd1);
  endtask

  task automatic do64(input string tag, input logic we, input logic [1:0] size, input logic sext,
                      input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                      input logic [7:0] exp_we, input logic [63:0] exp_wdata,
                      input logic [31:0] exp_addr, input logic [63:0] exp_rdata);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = we; b_req_size = size; b_req_sext = sext;
    b_req_addr = addr; b_req_wdata = wdata;
    tick();
    b_req_valid = 1'b0;
    chk({tag, ".en"}, 64'(b_mem_en), 64'd1);
    chk({tag, ".addr"}, 64'(b_mem_addr), 64'(exp_addr));
    chk({tag, ".we"}, 64'(b_mem_we), 64'(exp_we));
    if (we) chk({tag, ".wdata"}, b_mem_wdata, exp_wdata);
    b_mem_ack = 1'b1;
    b_mem_rdata = rdata;
    tick();
    b_mem_ack = 1'b0;
    chk({tag, ".resp_valid"}, 64'(b_resp_valid), 64'd1);
    chk({tag, ".rdata"}, b_resp_rdata, exp_rdata);
    tick();
    chk({tag, ".resp_done"}, 64'(b_resp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = 2'b00; a_req_sext = 1'b0;
    a_req_addr = 32'h0; a_req_wdata = 32'h0; a_mem_rdata = 32'h0; a_mem_ack = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'b00; b_req_sext = 1'b0;
    b_req_addr = 32'h0; b_req_wdata = 64'h0; b_mem_rdata = 64'h0; b_mem_ack = 1'b0;
    repeat (3) tick();
    chk("rst.ready", 64'(a_req_ready), 64'd1);
    chk("rst.resp_valid", 64'(a_resp_valid), 64'd0);
    chk("rst.rdata", 64'(a_resp_rdata), 64'd0);
    chk("rst.misalign", 64'(a_resp_misalign), 64'd0);
    chk("rst.en", 64'(a_mem_en), 64'd0);
    chk("rst.we", 64'(a_mem_we), 64'd0);
    chk("rst.addr", 64'(a_mem_addr), 64'd0);
    chk("rst.wdata", 64'(a_mem_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do32("sb_103", 1'b1, 2'b10, 1'b0, 32'h103, 32'h0000_00A5, 32'h0, 0,
         4'b1000, 32'hA5A5_A5A5, 32'h100, 32'h0);
    do32("lh_sext", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h8000_1234, 0,
         4'b0000, 32'h0, 32'h100, 32'hFFFF_8000);
    do32("lh_zext", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h8000_1234, 0,
         4'b0000, 32'h0, 32'h100, 32'h0000_8000);
    do32("lb_wait4", 1'b0, 2'b10, 1'b1, 32'h101, 32'h0, 32'h0000_7F00, 4,
         4'b0000, 32'h0, 32'h100, 32'h0000_007F);
    do32("lb_neg", 1'b0, 2'b10, 1'b1, 32'h203, 32'h0, 32'h8100_0000, 1,
         4'b0000, 32'h0, 32'h200, 32'hFFFF_FF81);
    do32("lw_sext", 1'b0, 2'b00, 1'b1, 32'h200, 32'h0, 32'hDEAD_BEEF, 0,
         4'b0000, 32'h0, 32'h200, 32'hDEAD_BEEF);
    do32("sh_102", 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234_BEEF, 32'h0, 0,
         4'b1100, 32'hBEEF_BEEF, 32'h100, 32'h0);
    do32("sd_as_sw", 1'b1, 2'b11, 1'b0, 32'h104, 32'h1122_3344, 32'h0, 2,
         4'b1111, 32'h1122_3344, 32'h104, 32'h0);

`ifdef MISALIGN_CHECK_EN
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_size = 2'b00; a_req_sext = 1'b0;
    a_req_addr = 32'h102; a_req_wdata = 32'hCAFE_F00D;
    tick();
    a_req_valid = 1'b0;
    chk("mis.resp_valid", 64'(a_resp_valid), 64'd1);
    chk("mis.flag", 64'(a_resp_misalign), 64'd1);
    chk("mis.rdata", 64'(a_resp_rdata), 64'd0);
    chk("mis.en", 64'(a_mem_en), 64'd0);
    chk("mis.we", 64'(a_mem_we), 64'd0);
    tick();
    chk("mis.resp_done", 64'(a_resp_valid), 64'd0);
    chk("mis.en_after", 64'(a_mem_en), 64'd0);
    chk("mis.flag_clr", 64'(a_resp_misalign), 64'd0);
`else
    do32("sw_mis", 1'b1, 2'b00, 1'b0, 32'h102, 32'hCAFE_F00D, 32'h0, 0,
         4'b1111, 32'hCAFE_F00D, 32'h100, 32'h0);
`endif

    // Reset while the access is waiting for its acknowledge.
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_size = 2'b10; a_req_sext = 1'b0;
    a_req_addr = 32'h301; a_req_wdata = 32'h0000_0077;
    tick();
    a_req_valid = 1'b0;
    chk("rstmid.en", 64'(a_mem_en), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid.ready", 64'(a_req_ready), 64'd1);
    chk("rstmid.resp_valid", 64'(a_resp_valid), 64'd0);
    chk("rstmid.en", 64'(a_mem_en), 64'd0);
    chk("rstmid.we", 64'(a_mem_we), 64'd0);
    chk("rstmid.addr", 64'(a_mem_addr), 64'd0);
    chk("rstmid.wdata", 64'(a_mem_wdata), 64'd0);
    chk("rstmid.rdata", 64'(a_resp_rdata), 64'd0);
    tick();
    chk("rstmid.no_resp", 64'(a_resp_valid), 64'd0);
    do32("after_rst", 1'b0, 2'b01, 1'b0, 32'h306, 32'h0, 32'hABCD_0000, 0,
         4'b0000, 32'h0, 32'h304, 32'h0000_ABCD);

    do64("ld_08", 1'b0, 2'b11, 1'b0, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF,
         8'h00, 64'h0, 32'h8, 64'h0123_4567_89AB_CDEF);
    do64("sw_0c", 1'b1, 2'b00, 1'b0, 32'hC, 64'h0000_0000_5566_7788, 64'h0,
         8'hF0, 64'h5566_7788_5566_7788, 32'h8, 64'h0);
    do64("lw_sext", 1'b0, 2'b00, 1'b1, 32'h4, 64'h0, 64'h8000_0000_0000_0000,
         8'h00, 64'h0, 32'h0, 64'hFFFF_FFFF_8000_0000);
    do64("sb_0f", 1'b1, 2'b10, 1'b0, 32'h1F, 64'h0000_0000_0000_003C, 64'h0,
         8'h80, 64'h3C3C_3C3C_3C3C_3C3C, 32'h18, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
